ldpc_posterior_update: RTL and testbench

LDPC_POSTERIOR_UPDATE -- requirements
Module: ldpc_posterior_update

---
 rtl/ldpc_posterior_update.sv | 164 ++++++++++++++++
 tb/tb_ldpc_posterior_update.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ldpc_posterior_update.sv
// LDPC layered-decoder posterior update: buffers Q vectors, adds incoming R, clamps to +/-127.
// Optional clamp-event counter o_sat_count is enabled with `define LDPC_POSTUPD_SAT_COUNT_EN.
module ldpc_posterior_update #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic       i_clock,
  input  logic       i_reset_n,
  input  logic [7:0] i_q_a0,
  input  logic [7:0] i_q_a1,
  input  logic [7:0] i_q_a2,
  input  logic [7:0] i_q_a3,
  input  logic [7:0] i_q_a4,
  input  logic [7:0] i_q_a5,
  input  logic [7:0] i_q_a6,
  input  logic       i_q_valid,
  input  logic [7:0] i_r_a0,
  input  logic [7:0] i_r_a1,
  input  logic [7:0] i_r_a2,
  input  logic [7:0] i_r_a3,
  input  logic [7:0] i_r_a4,
  input  logic [7:0] i_r_a5,
  input  logic [7:0] i_r_a6,
  input  logic       i_r_valid,
  output logic [7:0] o_data_a0,
  output logic [7:0] o_data_a1,
  output logic [7:0] o_data_a2,
  output logic [7:0] o_data_a3,
  output logic [7:0] o_data_a4,
  output logic [7:0] o_data_a5,
  output logic [7:0] o_data_a6,
  output logic [6:0] o_hard,
  output logic       o_syndrome,
  output logic       o_valid,
  output logic       o_overflow,
  output logic       o_underflow
`ifdef LDPC_POSTUPD_SAT_COUNT_EN
  ,
  output logic [15:0] o_sat_count
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [55:0]       fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       occupancy;
  logic              is_empty;
  logic              is_full;
  logic              push;
  logic              pop;
  logic [55:0]       q_vec;
  logic [55:0]       r_vec;
  logic [55:0]       q_head;
  logic [55:0]       data_q;
  logic [55:0]       data_next;
  logic [6:0]        hard_next;
  logic [6:0]        sat_flags;
  logic signed [8:0] lane_sum;

  assign q_vec = {i_q_a6, i_q_a5, i_q_a4, i_q_a3, i_q_a2, i_q_a1, i_q_a0};
  assign r_vec = {i_r_a6, i_r_a5, i_r_a4, i_r_a3, i_r_a2, i_r_a1, i_r_a0};

  assign is_empty = (occupancy == '0);
  assign is_full  = (occupancy == (AW+1)'(FIFO_DEPTH));
  assign pop      = i_r_valid & ~is_empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
  assign push     = i_q_valid & (~is_full | pop);
  assign q_head   = fifo_mem[rd_ptr];

  always_comb begin
    data_next = '0;
    hard_next = '0;
    sat_flags = '0;
    lane_sum  = '0;
    for (int k = 0; k < 7; k++) begin
      lane_sum = $signed({q_head[8*k+7], q_head[8*k +: 8]}) +
                 $signed({r_vec[8*k+7], r_vec[8*k +: 8]});
      // Symmetric clamp keeps -128 off the bus so negation stays safe downstream.
      if (lane_sum > 9'sd127) begin
        data_next[8*k +: 8] = 8'h7F;
        sat_flags[k]        = 1'b1;
      end else if (lane_sum < -9'sd127) begin
        data_next[8*k +: 8] = 8'h81;
        sat_flags[k]        = 1'b1;
      end else begin
        data_next[8*k +: 8] = lane_sum[7:0];
      end
      hard_next[k] = data_next[8*k+7];
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset_n && push) begin
      fifo_mem[wr_ptr] <= q_vec;
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      occupancy   <= '0;
      data_q      <= '0;
      o_hard      <= '0;
      o_syndrome  <= 1'b0;
      o_valid     <= 1'b0;
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      o_valid <= pop;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr     <= rd_ptr + 1'b1;
        data_q     <= data_next;
        o_hard     <= hard_next;
        o_syndrome <= ^hard_next;
      end
      case ({push, pop})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
      if (i_q_valid && is_full && !pop) begin
        o_overflow <= 1'b1;
      end
      if (i_r_valid && is_empty) begin
        o_underflow <= 1'b1;
      end
    end
  end

  assign o_data_a0 = data_q[7:0];
  assign o_data_a1 = data_q[15:8];
  assign o_data_a2 = data_q[23:16];
  assign o_data_a3 = data_q[31:24];
  assign o_data_a4 = data_q[39:32];
  assign o_data_a5 = data_q[47:40];
  assign o_data_a6 = data_q[55:48];

`ifdef LDPC_POSTUPD_SAT_COUNT_EN
  logic [2:0]  sat_lanes;
  logic [16:0] sat_sum;

  always_comb begin
    sat_lanes = '0;
    for (int k = 0; k < 7; k++) begin
      sat_lanes = sat_lanes + {2'b00, sat_flags[k]};
    end
    sat_sum = {1'b0, o_sat_count} + {14'b0, sat_lanes};
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      o_sat_count <= '0;
    end else if (pop) begin
      o_sat_count <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_ldpc_posterior_update.sv
// Scoreboard bench for ldpc_posterior_update: stimulus pushes expected vectors, a negedge monitor checks them.
module tb_ldpc_posterior_update;

  typedef struct {
    logic [55:0] data;
    logic [6:0]  hard;
    logic        syn;
  } exp_t;

  logic        i_clock = 1'b0;
  logic        i_reset_n;
  logic [55:0] q_vec;
  logic [55:0] r_vec;
  logic        i_q_valid;
  logic        i_r_valid;
  logic [7:0]  o_data_a0, o_data_a1, o_data_a2, o_data_a3, o_data_a4, o_data_a5, o_data_a6;
  logic [6:0]  o_hard;
  logic        o_syndrome;
  logic        o_valid;
  logic        o_overflow;
  logic        o_underflow;
  logic [55:0] got_data;
`ifdef LDPC_POSTUPD_SAT_COUNT_EN
  logic [15:0] o_sat_count;
`endif

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  always #5 i_clock = ~i_clock;

  assign got_data = {o_data_a6, o_data_a5, o_data_a4, o_data_a3, o_data_a2, o_data_a1, o_data_a0};

  ldpc_posterior_update #(.FIFO_DEPTH(8)) dut (
    .i_clock     (i_clock),
    .i_reset_n   (i_reset_n),
    .i_q_a0      (q_vec[7:0]),
    .i_q_a1      (q_vec[15:8]),
    .i_q_a2      (q_vec[23:16]),
    .i_q_a3      (q_vec[31:24]),
    .i_q_a4      (q_vec[39:32]),
    .i_q_a5      (q_vec[47:40]),
    .i_q_a6      (q_vec[55:48]),
    .i_q_valid   (i_q_valid),
    .i_r_a0      (r_vec[7:0]),
    .i_r_a1      (r_vec[15:8]),
    .i_r_a2      (r_vec[23:16]),
    .i_r_a3      (r_vec[31:24]),
    .i_r_a4      (r_vec[39:32]),
    .i_r_a5      (r_vec[47:40]),
    .i_r_a6      (r_vec[55:48]),
    .i_r_valid   (i_r_valid),
    .o_data_a0   (o_data_a0),
    .o_data_a1   (o_data_a1),
    .o_data_a2   (o_data_a2),
    .o_data_a3   (o_data_a3),
    .o_data_a4   (o_data_a4),
    .o_data_a5   (o_data_a5),
    .o_data_a6   (o_data_a6),
    .o_hard      (o_hard),
    .o_syndrome  (o_syndrome),
    .o_valid     (o_valid),
    .o_overflow  (o_overflow),
    .o_underflow (o_underflow)
`ifdef LDPC_POSTUPD_SAT_COUNT_EN
    ,
    .o_sat_count (o_sat_count)
`endif
  );

  function automatic exp_t model(logic [55:0] q, logic [55:0] r);
    exp_t e;
    int   s;
    e.data = '0;
    e.hard = '0;
    for (int k = 0; k < 7; k++) begin
      s = int'($signed(q[8*k +: 8])) + int'($signed(r[8*k +: 8]));
      if (s > 127) s = 127;
      if (s < -127) s = -127;
      e.data[8*k +: 8] = 8'(s);
      e.hard[k] = (s < 0);
    end
    e.syn = ^e.hard;
    return e;
  endfunction

  function automatic logic [55:0] all_lanes(logic [7:0] b);
    return {7{b}};
  endfunction

  function automatic logic [55:0] gen_q(int i);
    logic [55:0] v;
    for (int k = 0; k < 7; k++) v[8*k +: 8] = 8'(i * 37 + k * 53 - 90);
    return v;
  endfunction

  function automatic logic [55:0] gen_r(int i);
    logic [55:0] v;
    for (int k = 0; k < 7; k++) v[8*k +: 8] = 8'(i * 29 - k * 61 + 40);
    return v;
  endfunction

  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic do_reset();
    i_reset_n = 1'b0;
    tick();
    i_reset_n = 1'b1;
  endtask

  always @(negedge i_clock) begin
    if (o_valid) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_output: got data=%0h want no o_valid", got_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (got_data !== e.data || o_hard !== e.hard || o_syndrome !== e.syn) begin
          bad++;
          $display("FAIL output: got data=%0h hard=%0b syn=%0b want data=%0h hard=%0b syn=%0b",
                   got_data, o_hard, o_syndrome, e.data, e.hard, e.syn);
        end
      end
    end
  end

  initial begin
    exp_t e;
    i_reset_n = 1'b0;
    i_q_valid = 1'b0;
    i_r_valid = 1'b0;
    q_vec     = '0;
    r_vec     = '0;
    tick();
    tick();
    i_reset_n = 1'b1;
    chk("reset_valid", 64'(o_valid), 64'd0);
    chk("reset_data", 64'(got_data), 64'd0);
    chk("reset_hard_syn", 64'({o_hard, o_syndrome}), 64'd0);
    chk("reset_flags", 64'({o_overflow, o_underflow}), 64'd0);

    // single vector
    q_vec = all_lanes(8'd10);
    i_q_valid = 1'b1;
    tick();
    i_q_valid = 1'b0;
    r_vec = {8'd11, 8'd11, 8'hF5, 8'hF5, 8'd11, 8'hF5, 8'hEC};
    i_r_valid = 1'b1;
    e.data = {8'd21, 8'd21, 8'hFF, 8'hFF, 8'd21, 8'hFF, 8'hF6};
    e.hard = 7'b0011011;
    e.syn  = 1'b0;
    sb.push_back(e);
    tick();
    i_r_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("hold_data", 64'(got_data), 64'({8'd21, 8'd21, 8'hFF, 8'hFF, 8'd21, 8'hFF, 8'hF6}));
    chk("hold_valid_low", 64'(o_valid), 64'd0);

    // saturation both directions
    i_q_valid = 1'b1;
    q_vec = all_lanes(8'd100);
    tick();
    q_vec = all_lanes(8'h9C);
    tick();
    i_q_valid = 1'b0;
    i_r_valid = 1'b1;
    r_vec = all_lanes(8'd100);
    e.data = all_lanes(8'h7F); e.hard = 7'h00; e.syn = 1'b0;
    sb.push_back(e);
    tick();
    r_vec = all_lanes(8'h9C);
    e.data = all_lanes(8'h81); e.hard = 7'h7F; e.syn = 1'b1;
    sb.push_back(e);
    tick();
    i_r_valid = 1'b0;
    tick();
`ifdef LDPC_POSTUPD_SAT_COUNT_EN
    chk("sat_count", 64'(o_sat_count), 64'd14);
`endif

    // pipelined: 16 Q back-to-back, R trailing by 3 cycles
    for (int c = 0; c < 19; c++) begin
      i_q_valid = (c < 16);
      q_vec     = gen_q(c);
      i_r_valid = (c >= 3);
      if (c >= 3) begin
        r_vec = gen_r(c - 3);
        sb.push_back(model(gen_q(c - 3), gen_r(c - 3)));
      end
      tick();
    end
    i_q_valid = 1'b0;
    i_r_valid = 1'b0;
    tick();
    chk("pipe_flags", 64'({o_overflow, o_underflow}), 64'd0);
    chk("pipe_sb_drained", 64'(sb.size()), 64'd0);

    // full FIFO, push+pop while full, then overflow
    do_reset();
    i_q_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      q_vec = gen_q(i + 20);
      tick();
    end
    q_vec = gen_q(28);
    r_vec = '0;
    i_r_valid = 1'b1;
    sb.push_back(model(gen_q(20), '0));
    tick();
    i_r_valid = 1'b0;
    chk("full_pushpop_no_ovf", 64'(o_overflow), 64'd0);
    q_vec = gen_q(99);
    tick();
    i_q_valid = 1'b0;
    chk("overflow_set", 64'(o_overflow), 64'd1);
    i_r_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      r_vec = gen_r(i + 40);
      sb.push_back(model(gen_q(i + 21), gen_r(i + 40)));
      tick();
    end
    chk("no_underflow_yet", 64'(o_underflow), 64'd0);
    // FIFO now empty: this R must be rejected
    tick();
    i_r_valid = 1'b0;
    tick();
    chk("underflow_set", 64'(o_underflow), 64'd1);
    chk("sb_after_full", 64'(sb.size()), 64'd0);
    do_reset();
    chk("rst_flags", 64'({o_overflow, o_underflow}), 64'd0);
    chk("rst_data", 64'(got_data), 64'd0);
    chk("rst_hard_syn", 64'({o_hard, o_syndrome}), 64'd0);

    // mid-run reset; valids held high during reset must be ignored
    i_q_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      q_vec = gen_q(i + 50);
      tick();
    end
    i_reset_n = 1'b0;
    i_r_valid = 1'b1;
    tick();
    i_reset_n = 1'b1;
    i_q_valid = 1'b0;
    tick();
    i_r_valid = 1'b0;
    tick();
    chk("midrst_underflow", 64'(o_underflow), 64'd1);
    chk("midrst_overflow", 64'(o_overflow), 64'd0);

    // simultaneous push and R into empty FIFO: push kept, no output
    do_reset();
    q_vec = gen_q(60);
    r_vec = gen_r(60);
    i_q_valid = 1'b1;
    i_r_valid = 1'b1;
    tick();
    i_q_valid = 1'b0;
    chk("push_empty_underflow", 64'(o_underflow), 64'd1);
    r_vec = gen_r(61);
    sb.push_back(model(gen_q(60), gen_r(61)));
    tick();
    i_r_valid = 1'b0;
    tick();
    tick();
    chk("final_sb_drained", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
